sdram_cmd_arbiter: RTL and testbench

//  Front-end scheduler for the SDRAM command detector stage. Runs the power-up init

---
 rtl/sdram_cmd_arbiter.sv | 133 +++++++++++++
 tb/tb_sdram_cmd_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command front-end: power-up init sequence, periodic refresh, two-port arbitration.
// Optional macro SDRAM_ARB_RR_EN selects round-robin between ports (default: port 0 fixed priority).
module sdram_cmd_arbiter #(
  parameter int unsigned      CNT_W        = 16,
  parameter logic [CNT_W-1:0] INIT_CYCLES  = CNT_W'(200),
  parameter logic [CNT_W-1:0] REF_INTERVAL = CNT_W'(1560)
) (
  input  logic clk0,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic we0,
  input  logic we1,
  output logic gnt0,
  output logic gnt1,
  input  logic cmd_ack,
  input  logic cmd_busy,
  output logic nop,
  output logic ref_req,
  output logic reada,
  output logic writea,
  output logic preacharge,
  output logic load_mod,
  output logic init_done,
  output logic ref_overrun
);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_WAIT_PRE, S_INIT_REF1, S_WAIT_REF1,
    S_INIT_REF2, S_WAIT_REF2, S_INIT_LMR, S_WAIT_LMR, S_IDLE, S_ISSUE, S_WAIT
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_init_cnt, r_ref_cnt;
  logic             r_ref_pending, r_ref_overrun, r_init_done;
  logic             r_sel_valid, r_sel_ref, r_sel_port, r_sel_we;
  logic             w_pre, w_ref, w_rd, w_wr, w_lmr;
  logic             w_quiet, w_expire, w_ref_clr, w_issue_ack, w_pick_port;

  assign w_quiet     = !cmd_busy && !cmd_ack;
  assign w_expire    = r_init_done && (r_ref_cnt == '0);
  assign w_ref_clr   = w_ref && cmd_ack;
  assign w_issue_ack = (r_state == S_ISSUE) && cmd_ack && !r_sel_ref;

`ifdef SDRAM_ARB_RR_EN
  logic r_rr;
  assign w_pick_port = (req0 && req1) ? r_rr : req1;

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset)            r_rr <= 1'b0;
    else if (w_issue_ack) r_rr <= ~r_sel_port;
  end
`else
  assign w_pick_port = !req0;
`endif

  always_comb begin
    w_next = r_state;
    w_pre  = 1'b0;
    w_ref  = 1'b0;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_lmr  = 1'b0;
    case (r_state)
      S_INIT_WAIT: if (r_init_cnt == '0) w_next = S_INIT_PRE;
      S_INIT_PRE:  begin w_pre = 1'b1; if (cmd_ack) w_next = S_WAIT_PRE;  end
      S_WAIT_PRE:  if (w_quiet) w_next = S_INIT_REF1;
      S_INIT_REF1: begin w_ref = 1'b1; if (cmd_ack) w_next = S_WAIT_REF1; end
      S_WAIT_REF1: if (w_quiet) w_next = S_INIT_REF2;
      S_INIT_REF2: begin w_ref = 1'b1; if (cmd_ack) w_next = S_WAIT_REF2; end
      S_WAIT_REF2: if (w_quiet) w_next = S_INIT_LMR;
      S_INIT_LMR:  begin w_lmr = 1'b1; if (cmd_ack) w_next = S_WAIT_LMR;  end
      S_WAIT_LMR:  if (w_quiet) w_next = S_IDLE;
      // Selection is registered while in IDLE; the command level follows one cycle later.
      S_IDLE:      if (r_sel_valid) w_next = S_ISSUE;
      S_ISSUE: begin
        if (r_sel_ref)     w_ref = 1'b1;
        else if (r_sel_we) w_wr  = 1'b1;
        else               w_rd  = 1'b1;
        if (cmd_ack) w_next = S_WAIT;
      end
      S_WAIT:      if (w_quiet) w_next = S_IDLE;
      default:     w_next = S_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      r_state       <= S_INIT_WAIT;
      r_init_cnt    <= INIT_CYCLES;
      r_ref_cnt     <= REF_INTERVAL;
      r_ref_pending <= 1'b0;
      r_ref_overrun <= 1'b0;
      r_init_done   <= 1'b0;
      r_sel_valid   <= 1'b0;
      r_sel_ref     <= 1'b0;
      r_sel_port    <= 1'b0;
      r_sel_we      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_INIT_WAIT && r_init_cnt != '0) r_init_cnt <= r_init_cnt - CNT_W'(1);
      if (r_state == S_WAIT_LMR && w_quiet) r_init_done <= 1'b1;
      if (r_init_done) begin
        if (r_ref_cnt == '0) r_ref_cnt <= REF_INTERVAL;
        else                 r_ref_cnt <= r_ref_cnt - CNT_W'(1);
      end
      // A new expiry outranks a same-cycle clear so that request is not lost.
      if (w_expire)       r_ref_pending <= 1'b1;
      else if (w_ref_clr) r_ref_pending <= 1'b0;
      if (w_expire && r_ref_pending && !w_ref_clr) r_ref_overrun <= 1'b1;
      if (r_state == S_IDLE && !r_sel_valid) begin
        r_sel_valid <= r_ref_pending | req0 | req1;
        r_sel_ref   <= r_ref_pending;
        r_sel_port  <= w_pick_port;
        r_sel_we    <= w_pick_port ? we1 : we0;
      end else if (r_state == S_ISSUE && cmd_ack) begin
        r_sel_valid <= 1'b0;
      end
    end
  end

  assign gnt0        = w_issue_ack && !r_sel_port;
  assign gnt1        = w_issue_ack &&  r_sel_port;
  assign preacharge  = w_pre;
  assign ref_req     = w_ref;
  assign reada       = w_rd;
  assign writea      = w_wr;
  assign load_mod    = w_lmr;
  assign nop         = !(w_pre || w_ref || w_rd || w_wr || w_lmr);
  assign init_done   = r_init_done;
  assign ref_overrun = r_ref_overrun;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Scoreboard bench for sdram_cmd_arbiter: expected commands/grants queued by stimulus, popped by monitor.
module tb_sdram_cmd_arbiter;
  localparam int RI       = 30;
  localparam int ACK_DLY  = 1;
  localparam int BUSY_LEN = 3;
  localparam int C_PRE = 1, C_REF = 2, C_RD = 3, C_WR = 4, C_LMR = 5;

  logic clk0 = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic cmd_ack = 1'b0, cmd_busy = 1'b0;
  logic gnt0, gnt1, nop, ref_req, reada, writea, preacharge, load_mod, init_done, ref_overrun;

  int n_checks = 0, n_fail = 0;
  int q_cmd[$];
  int q_gnt[$];
  int refs_seen = 0, gnts_seen = 0;
  int prev_cur = 0;
  logic blk_ref = 1'b0, blk_wr = 1'b0;
  int ack_dly = ACK_DLY, busy_left = 0;

  // Reference refresh model
  int m_cnt = RI, cyc = 0, m_exp_cyc = 0;
  logic m_pend = 1'b0, m_ovr = 1'b0;
  logic m_exp_w, m_clr_w;

  sdram_cmd_arbiter #(.CNT_W(16), .INIT_CYCLES(16'd8), .REF_INTERVAL(16'(RI))) dut (
    .clk0(clk0), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1), .cmd_ack(cmd_ack), .cmd_busy(cmd_busy), .nop(nop),
    .ref_req(ref_req), .reada(reada), .writea(writea), .preacharge(preacharge),
    .load_mod(load_mod), .init_done(init_done), .ref_overrun(ref_overrun));

  always #5 clk0 = ~clk0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int code_of(input logic [4:0] lv);
    if (lv[4]) return C_PRE;
    if (lv[3]) return C_REF;
    if (lv[2]) return C_RD;
    if (lv[1]) return C_WR;
    if (lv[0]) return C_LMR;
    return 0;
  endfunction

  assign m_exp_w = init_done && (m_cnt == 0);
  assign m_clr_w = cmd_ack && ref_req;

  always @(posedge clk0 or posedge reset) begin
    if (reset) begin
      m_cnt <= RI; m_pend <= 1'b0; m_ovr <= 1'b0; cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (init_done) m_cnt <= (m_cnt == 0) ? RI : m_cnt - 1;
      if (m_exp_w) begin
        m_pend <= 1'b1;
        m_exp_cyc <= cyc + 1;
        if (m_pend && !m_clr_w) m_ovr <= 1'b1;
      end else if (m_clr_w) m_pend <= 1'b0;
    end
  end

  // Detector stand-in: ack after a short delay, then busy for a few cycles.
  always @(negedge clk0) begin
    if (reset) begin
      cmd_ack = 1'b0; cmd_busy = 1'b0; busy_left = 0; ack_dly = ACK_DLY;
    end else begin
      if (cmd_ack) begin
        cmd_ack = 1'b0; busy_left = BUSY_LEN;
      end else if (!nop && !(blk_ref && ref_req) && !(blk_wr && writea)) begin
        if (ack_dly == 0) begin cmd_ack = 1'b1; ack_dly = ACK_DLY; end
        else ack_dly--;
      end
      cmd_busy = (busy_left != 0);
      if (busy_left != 0) busy_left--;
    end
  end

  always @(negedge clk0) begin
    int cur, nlv, g;
    #1;
    cur = code_of({preacharge, ref_req, reada, writea, load_mod});
    nlv = int'(preacharge) + int'(ref_req) + int'(reada) + int'(writea) + int'(load_mod);
    if (!reset) begin
      chk("onehot", int'(nlv <= 1), 1);
      chk("nop_level", int'(nop), int'(nlv == 0));
      if (cur != 0 && cur != prev_cur) begin
        if (cur == C_REF && init_done) begin
          refs_seen++;
          chk("ref_has_cause", int'(m_pend), 1);
        end else if (q_cmd.size() == 0) chk("cmd_unexpected", cur, 0);
        else chk("cmd_order", cur, q_cmd.pop_front());
        if ((cur == C_RD || cur == C_WR) && m_pend) chk("ref_before_rw", int'((cyc - m_exp_cyc) < 2), 1);
      end
      if (gnt0 || gnt1) begin
        chk("gnt_single", int'(gnt0 && gnt1), 0);
        g = gnt1 ? 1 : 0;
        gnts_seen++;
        if (q_gnt.size() == 0) chk("gnt_unexpected", g + 1, 0);
        else chk("gnt_port", g, q_gnt.pop_front());
      end
      chk("overrun", int'(ref_overrun), int'(m_ovr));
    end
    prev_cur = reset ? 0 : cur;
  end

  task automatic sample();
    @(negedge clk0); #1;
  endtask

  task automatic wait_gnts(input int target, input int budget, input string name);
    int i;
    for (i = 0; i < budget && gnts_seen < target; i++) sample();
    chk(name, int'(gnts_seen >= target), 1);
  endtask

  task automatic run_init();
    int i;
    q_cmd.push_back(C_PRE); q_cmd.push_back(C_REF); q_cmd.push_back(C_REF); q_cmd.push_back(C_LMR);
    for (int k = 0; k < 8; k++) begin
      sample();
      chk("init_wait_nop", int'({nop, preacharge, ref_req, load_mod, init_done}), 16);
    end
    sample();
    chk("init_pre_first", int'(preacharge), 1);
    for (i = 0; i < 100 && !load_mod; i++) sample();
    chk("init_lmr_not_done", int'(init_done), 0);
    for (i = 0; i < 100 && !init_done; i++) sample();
    chk("init_done", int'(init_done), 1);
    chk("init_busy_clear", int'(cmd_busy), 0);
  endtask

  initial begin
    int i, g0;
    repeat (3) @(negedge clk0);
    #1;
    chk("rst_nop", int'(nop), 1);
    chk("rst_outs", int'({gnt0, gnt1, ref_req, reada, writea, preacharge, load_mod, init_done, ref_overrun}), 0);
    reset = 1'b0;
    // T1
    run_init();
    // T2: single read, 2-cycle latency
    sample();
    q_cmd.push_back(C_RD); q_gnt.push_back(0);
    req0 = 1'b1; we0 = 1'b0;
    sample(); chk("t2_lat1", int'(reada), 0);
    sample(); chk("t2_lat2", int'(reada), 1);
    for (i = 0; i < 20 && !gnt0; i++) sample();
    chk("t2_gnt0", int'(gnt0), 1);
    sample(); req0 = 1'b0;
    chk("t2_reada_drop", int'(reada), 0);
    chk("t2_gnt_pulse", int'(gnt0), 0);
    for (i = 0; i < 10 && cmd_busy; i++) begin
      chk("t2_quiet", int'(nop), 1);
      sample();
    end
    // T3: continuous port-0 reads interleaved with refresh
    g0 = gnts_seen;
    i = refs_seen;
    for (int k = 0; k < 8; k++) begin q_cmd.push_back(C_RD); q_gnt.push_back(0); end
    req0 = 1'b1; we0 = 1'b0;
    wait_gnts(g0 + 8, 600, "t3_gnts");
    req0 = 1'b0;
    chk("t3_refresh_seen", int'(refs_seen > i), 1);
    repeat (12) sample();
    // T4: both ports requesting continuously
    g0 = gnts_seen;
    for (int k = 0; k < 6; k++) begin
`ifdef SDRAM_ARB_RR_EN
      if (k % 2 == 0) begin q_cmd.push_back(C_WR); q_gnt.push_back(1); end
      else begin q_cmd.push_back(C_RD); q_gnt.push_back(0); end
`else
      q_cmd.push_back(C_RD); q_gnt.push_back(0);
`endif
    end
    req0 = 1'b1; we0 = 1'b0; req1 = 1'b1; we1 = 1'b1;
    wait_gnts(g0 + 6, 600, "t4_gnts");
    req0 = 1'b0; req1 = 1'b0;
    repeat (12) sample();
    // T5: refresh never acked across two expiries
    blk_ref = 1'b1;
    for (i = 0; i < 4 * RI && !ref_req; i++) sample();
    chk("t5_ref_held", int'(ref_req), 1);
    repeat (2 * (RI + 1) + 4) sample();
    chk("t5_overrun", int'(ref_overrun), 1);
    blk_ref = 1'b0;
    repeat (20) sample();
    chk("t5_sticky", int'(ref_overrun), 1);
    // T6: reset while writea held
    blk_wr = 1'b1;
    g0 = gnts_seen;
    q_cmd.push_back(C_WR);
    req1 = 1'b1; we1 = 1'b1;
    for (i = 0; i < 100 && !writea; i++) sample();
    chk("t6_writea_held", int'(writea), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_nop", int'(nop), 1);
    chk("t6_rst_outs", int'({gnt0, gnt1, ref_req, reada, writea, preacharge, load_mod, init_done, ref_overrun}), 0);
    chk("t6_cmd_q_empty", q_cmd.size(), 0);
    req1 = 1'b0; we1 = 1'b0; blk_wr = 1'b0;
    repeat (2) @(negedge clk0);
    #1 reset = 1'b0;
    run_init();
    chk("t6_no_gnt1", gnts_seen, g0);
    repeat (10) sample();
    chk("end_cmd_q", q_cmd.size(), 0);
    chk("end_gnt_q", q_gnt.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
